matmul_job_arbiter: RTL and testbench
=====================================

MATMUL_JOB_ARBITER -- requirements
Module: matmul_job_arbiter

Interface
REQ-001 Parameters SHALL be: DW, default 8, operand element width; AW, default 16, result element width; NREQ, default 4, requester count; TIMEOUT, default 255, maximum engine cycles.
REQ-002 The design SHALL use one clock. Reset is synchronous and active-low.
REQ-003 Port: clk  in  1  rising-edge clock.
REQ-004 Port: reset  in  1  synchronous, active-low reset.
REQ-005 Port: req_valid  in  NREQ  job request, one bit per requester.
REQ-006 Port: req_ready  out  NREQ  one-hot job acceptance.
REQ-007 Port: req_A  in  NREQ*DW*64  flattened A operand per requester; requester i uses slice i.
REQ-008 Port: req_B  in  NREQ*DW*64  flattened B operand per requester.
REQ-009 Port: eng_start  out  1  single-cycle engine start pulse.
REQ-010 Port: eng_A, eng_B  out  DW*64 each  registered engine operands.
REQ-011 Port: eng_done  in  1  engine completion.
REQ-012 Port: eng_C  in  AW*64  engine result.
REQ-013 Port: rsp_valid  out  NREQ  one-hot result valid.
REQ-014 Port: rsp_ready  in  NREQ  result accept.
REQ-015 Port: rsp_C  out  AW*64  registered result.
REQ-016 Port: rsp_err  out  1  result invalid because of a timeout.
REQ-017 Port: busy  out  1  high in every state except IDLE.

Function
REQ-018 The FSM SHALL have four states, IDLE, ISSUE, WAIT and RESP, with the following transitions:
- IDLE->ISSUE when any req_valid is set.
- ISSUE->WAIT unconditionally.
- WAIT->RESP on eng_done or on timeout.
- RESP->IDLE on handshake.
REQ-019 In IDLE with any req_valid, the arbiter SHALL choose a winner by round-robin from pointer ptr, then:
- assert req_ready[winner] for exactly that cycle;
- latch its operands into eng_A and eng_B;
- record the owner index.
REQ-020 After a grant, ptr SHALL become (winner+1) mod NREQ. Requests that are not granted SHALL be ignored without side effects.
REQ-021 eng_start SHALL be high only in the ISSUE cycle, so one start is issued per accepted job.
REQ-022 eng_A and eng_B SHALL hold steady from ISSUE until the FSM leaves RESP.
REQ-023 eng_done SHALL be sampled only in WAIT. Any eng_done seen in ISSUE SHALL be ignored.
REQ-024 In WAIT, an 8-bit-minimum counter SHALL count cycles.
- If eng_done arrives first: capture eng_C into rsp_C and clear rsp_err.
- If the count reaches TIMEOUT first: set rsp_err, leave rsp_C unchanged, go to RESP.
- If eng_done and timeout occur in the same cycle, done wins and rsp_err stays 0.
REQ-025 In RESP, rsp_valid[owner] SHALL stay high, with rsp_C and rsp_err stable, until rsp_ready[owner] is high. The FSM leaves RESP that cycle.
REQ-026 rsp_ready bits of non-owners SHALL be ignored.
REQ-027 No req_ready SHALL be asserted outside IDLE, so jobs never overlap.
REQ-028 rsp_C SHALL be a plain register copy; the arbiter does no arithmetic on it.

Reset
REQ-029 On a clk edge with reset=0, the block SHALL enter IDLE and clear all of the following:
- ptr, owner and the timeout counter set to 0;
- req_ready, eng_start, rsp_valid, rsp_err and busy set to 0;
- eng_A, eng_B and rsp_C set to 0.
REQ-030 A reset during ISSUE, WAIT or RESP SHALL abort the job with no response. A late eng_done after reset SHALL be ignored because the FSM is in IDLE.

Structure
REQ-031 A shared package SHALL hold the state encoding, the DW, AW and NREQ defaults, TIMEOUT, and the flattened-matrix width constants (DW*64, AW*64).
REQ-032 One sub-module, rr_arbiter, SHALL implement the combinational round-robin one-hot select with ptr as input. The FSM, registers and timeout counter SHALL stay in the top module.

Verification
REQ-033 Single job on requester 0. A rows are {1..8}, {8..1}, etc.; B rows alternate 1,0,1,0 / 0,1,0,1. Behavioural engine returns done 20 cycles after start.
- Expect exactly one eng_start.
- Expect rsp_valid=4'b0001.
- Expect rsp_C element C[0][0]=16, C[0][1]=20, C[1][0]=20, C[1][1]=16.
- Expect rsp_err=0.
REQ-034 Round-robin order:
- req_valid=4'b1111 after reset -> grants in order 0,1,2,3, one per job.
- Next, req_valid=4'b0101 with ptr=0 -> order 0,2.
REQ-035 Backpressure: hold rsp_ready low for 5 cycles in RESP.
- rsp_valid and rsp_C stay stable.
- No req_ready or eng_start occurs.
- IDLE is reached the cycle after rsp_ready rises.
REQ-036 Timeout: engine never asserts done -> after 255 WAIT cycles, rsp_valid[owner]=1 with rsp_err=1, then return to IDLE.
REQ-037 Timeout collision: eng_done arrives on the 255th WAIT cycle -> rsp_err=0 and rsp_C is captured.
REQ-038 Reset mid-WAIT: reset=0 for 1 cycle -> next cycle busy=0 and all outputs are 0. A following eng_done pulse produces no rsp_valid.

Source files
------------

// File: rtl/matmul_job_arbiter_pkg.sv
// Shared state encoding, default sizing and width helpers for the matmul job arbiter.
package matmul_job_arbiter_pkg;

    localparam int DW_DEF      = 8;
    localparam int AW_DEF      = 16;
    localparam int NREQ_DEF    = 4;
    localparam int TIMEOUT_DEF = 255;

    localparam int MAT_ELEMS   = 64;
    localparam int MAT_A_W_DEF = DW_DEF * MAT_ELEMS;
    localparam int MAT_C_W_DEF = AW_DEF * MAT_ELEMS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Timeout counter is never narrower than 8 bits.
    function automatic int cnt_width(input int timeout);
        int w;
        w = 8;
        while ((64'd1 << w) <= 64'(timeout)) w++;
        return w;
    endfunction

endpackage

// File: rtl/matmul_job_arbiter_rr_arbiter.sv
// Combinational round-robin select: the first requester at or after i_ptr wins.
module rr_arbiter
    import matmul_job_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int PW   = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [PW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [PW-1:0]   o_idx,
    output logic            o_any
);

    // Scan from the farthest offset down so the closest requester is written last.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (i_req[PW'((int'(i_ptr) + i) % NREQ)]) begin
                o_idx   = PW'((int'(i_ptr) + i) % NREQ);
                o_grant = NREQ'(1) << o_idx;
            end
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/matmul_job_arbiter.sv
// Job arbiter: grants NREQ requesters round-robin onto one 8x8 matmul engine,
// follows each job through start, wait and response, and flags engine timeouts.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | no job; grant the round-robin winner when any request is up
//   ST_ISSUE | operands latched, eng_start high for this one cycle
//   ST_WAIT  | waiting for eng_done, timeout counter running
//   ST_RESP  | rsp_valid[owner] held until that owner accepts
module matmul_job_arbiter
    import matmul_job_arbiter_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int AW      = AW_DEF,
    parameter int NREQ    = NREQ_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NREQ-1:0]                 req_valid,
    output logic [NREQ-1:0]                 req_ready,
    input  logic [NREQ*DW*MAT_ELEMS-1:0]    req_A,
    input  logic [NREQ*DW*MAT_ELEMS-1:0]    req_B,
    output logic                            eng_start,
    output logic [DW*MAT_ELEMS-1:0]         eng_A,
    output logic [DW*MAT_ELEMS-1:0]         eng_B,
    input  logic                            eng_done,
    input  logic [AW*MAT_ELEMS-1:0]         eng_C,
    output logic [NREQ-1:0]                 rsp_valid,
    input  logic [NREQ-1:0]                 rsp_ready,
    output logic [AW*MAT_ELEMS-1:0]         rsp_C,
    output logic                            rsp_err,
    output logic                            busy
);

    localparam int AMW = DW * MAT_ELEMS;
    localparam int CMW = AW * MAT_ELEMS;
    localparam int PW  = idx_width(NREQ);
    localparam int CW  = cnt_width(TIMEOUT);

    state_t          r_state;
    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   r_owner;
    logic [CW-1:0]   r_cnt;
    logic            r_eng_start;
    logic [AMW-1:0]  r_eng_A;
    logic [AMW-1:0]  r_eng_B;
    logic [NREQ-1:0] r_rsp_valid;
    logic [CMW-1:0]  r_rsp_C;
    logic            r_rsp_err;
    logic            r_busy;

    logic [NREQ-1:0] w_grant;
    logic [PW-1:0]   w_win;
    logic            w_any;
    logic [NREQ-1:0] w_owner_hot;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_arbiter (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_win),
        .o_any   (w_any)
    );

    assign w_owner_hot = NREQ'(1) << r_owner;

    // Gated by reset so no requester sees an acceptance that the FSM will not take.
    assign req_ready = (r_state == ST_IDLE && reset) ? w_grant : '0;

    assign eng_start = r_eng_start;
    assign eng_A     = r_eng_A;
    assign eng_B     = r_eng_B;
    assign rsp_valid = r_rsp_valid;
    assign rsp_C     = r_rsp_C;
    assign rsp_err   = r_rsp_err;
    assign busy      = r_busy;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_owner     <= '0;
            r_cnt       <= '0;
            r_eng_start <= 1'b0;
            r_eng_A     <= '0;
            r_eng_B     <= '0;
            r_rsp_valid <= '0;
            r_rsp_C     <= '0;
            r_rsp_err   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_eng_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_eng_A     <= req_A[w_win*AMW +: AMW];
                        r_eng_B     <= req_B[w_win*AMW +: AMW];
                        r_owner     <= w_win;
                        r_ptr       <= (w_win == PW'(NREQ - 1)) ? '0 : w_win + 1'b1;
                        r_eng_start <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Down-counter reaches zero on the TIMEOUT-th WAIT cycle.
                    r_cnt   <= CW'(TIMEOUT - 1);
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (eng_done) begin
                        r_rsp_C     <= eng_C;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= w_owner_hot;
                        r_state     <= ST_RESP;
                    end else if (r_cnt == '0) begin
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= w_owner_hot;
                        r_state     <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready[r_owner]) begin
                        r_rsp_valid <= '0;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_job_arbiter.sv
// Randomized job-level bench for matmul_job_arbiter with a behavioural engine and
// a transaction model of grant order, response latency and response contents.
module tb_matmul_job_arbiter;

    localparam int DW      = 8;
    localparam int AW      = 16;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 255;
    localparam int MAT     = 64;
    localparam int AMW     = DW * MAT;
    localparam int CMW     = AW * MAT;

    logic                  clk;
    logic                  reset;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*AMW-1:0]   req_A;
    logic [NREQ*AMW-1:0]   req_B;
    logic                  eng_start;
    logic [AMW-1:0]        eng_A;
    logic [AMW-1:0]        eng_B;
    logic                  eng_done;
    logic [CMW-1:0]        eng_C;
    logic [NREQ-1:0]       rsp_valid;
    logic [NREQ-1:0]       rsp_ready;
    logic [CMW-1:0]        rsp_C;
    logic                  rsp_err;
    logic                  busy;

    matmul_job_arbiter #(
        .DW      (DW),
        .AW      (AW),
        .NREQ    (NREQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_A     (req_A),
        .req_B     (req_B),
        .eng_start (eng_start),
        .eng_A     (eng_A),
        .eng_B     (eng_B),
        .eng_done  (eng_done),
        .eng_C     (eng_C),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_C     (rsp_C),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp   = 0;
    int n_bad   = 0;
    int n_start = 0;
    int m_starts = 0;
    int m_ptr   = 0;
    logic [CMW-1:0] m_last_C = '0;
    logic [AMW-1:0] op_A [NREQ];
    logic [AMW-1:0] op_B [NREQ];

    always @(posedge clk) if (eng_start === 1'b1) n_start++;

    task automatic chk(input string tag, input logic [AMW-1:0] got, input logic [AMW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_c(input string tag, input logic [CMW-1:0] got, input logic [CMW-1:0] exp);
        int e;
        e = 0;
        for (int i = MAT - 1; i >= 0; i--)
            if (got[i*AW +: AW] !== exp[i*AW +: AW]) e = i;
        chk($sformatf("%s[%0d]", tag, e), AMW'(got[e*AW +: AW]), AMW'(exp[e*AW +: AW]));
    endtask

    task automatic nxt();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [CMW-1:0] rnd_c();
        logic [CMW-1:0] v;
        for (int i = 0; i < CMW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [NREQ-1:0] rnd_mask();
        return NREQ'($urandom);
    endfunction

    // Row-major 8x8 product, each element truncated to AW bits.
    function automatic logic [CMW-1:0] matmul(input logic [AMW-1:0] a, input logic [AMW-1:0] b);
        logic [CMW-1:0] c;
        logic [31:0]    acc;
        c = '0;
        for (int r = 0; r < 8; r++)
            for (int col = 0; col < 8; col++) begin
                acc = 0;
                for (int k = 0; k < 8; k++)
                    acc += 32'(a[(r*8+k)*DW +: DW]) * 32'(b[(k*8+col)*DW +: DW]);
                c[(r*8+col)*AW +: AW] = acc[AW-1:0];
            end
        return c;
    endfunction

    // Lowest requesting index at or above the pointer, else lowest requesting index.
    function automatic int rr_pick(input logic [NREQ-1:0] m, input int p);
        int best;
        best = -1;
        for (int i = 0; i < NREQ; i++) if (m[i] && i >= p && best < 0) best = i;
        if (best < 0)
            for (int i = 0; i < NREQ; i++) if (m[i] && best < 0) best = i;
        return best;
    endfunction

    task automatic rand_ops();
        for (int i = 0; i < NREQ; i++)
            for (int w = 0; w < AMW / 32; w++) begin
                op_A[i][w*32 +: 32] = $urandom;
                op_B[i][w*32 +: 32] = $urandom;
            end
    endtask

    task automatic drive_ops();
        for (int i = 0; i < NREQ; i++) begin
            req_A[i*AMW +: AMW] = op_A[i];
            req_B[i*AMW +: AMW] = op_B[i];
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req_valid = '0;
        nxt();
        reset = 1'b1;
        m_ptr = 0;
        m_last_C = '0;
    endtask

    // d: WAIT cycle carrying eng_done (0 = engine never answers); hold: RESP cycles before accept.
    task automatic run_job(input logic [NREQ-1:0] mask, input int d, input int hold,
                           input bit spur, output int win);
        logic [NREQ-1:0] exp_hot;
        logic [CMW-1:0]  exp_C;
        logic [CMW-1:0]  eng_res;
        logic            exp_err;
        int              exp_k;
        int              bad;
        win     = rr_pick(mask, m_ptr);
        exp_hot = NREQ'(1) << win;
        exp_err = (d < 1 || d > TIMEOUT);
        exp_k   = exp_err ? TIMEOUT : d;
        exp_C   = exp_err ? m_last_C : matmul(op_A[win], op_B[win]);
        drive_ops();
        req_valid = mask;
        rsp_ready = '0;
        eng_done  = 1'b0;
        #1;
        chk("idle_busy", AMW'(busy), '0);
        chk("grant", AMW'(req_ready), AMW'(exp_hot));
        nxt();
        req_valid = rnd_mask();
        eng_done  = spur;
        eng_C     = rnd_c();
        #1;
        chk("issue_start", AMW'(eng_start), 1);
        chk("issue_ready", AMW'(req_ready), '0);
        chk("issue_busy", AMW'(busy), 1);
        chk("eng_A", eng_A, op_A[win]);
        chk("eng_B", eng_B, op_B[win]);
        eng_res = matmul(eng_A, eng_B);
        m_starts++;
        nxt();
        bad = 0;
        for (int k = 1; k <= exp_k; k++) begin
            req_valid = rnd_mask();
            eng_done  = (k == d);
            eng_C     = (k == d) ? eng_res : rnd_c();
            #1;
            if (eng_start !== 1'b0 || req_ready !== '0 || rsp_valid !== '0 ||
                busy !== 1'b1 || eng_A !== op_A[win] || eng_B !== op_B[win]) bad++;
            nxt();
        end
        chk("wait_quiet", AMW'(bad), '0);
        bad = 0;
        for (int j = 0; j < hold; j++) begin
            req_valid = rnd_mask();
            rsp_ready = rnd_mask() & ~exp_hot;
            eng_done  = 1'($urandom);
            eng_C     = rnd_c();
            #1;
            if (rsp_valid !== exp_hot || rsp_C !== exp_C || rsp_err !== exp_err ||
                req_ready !== '0 || eng_start !== 1'b0 || busy !== 1'b1 ||
                eng_A !== op_A[win] || eng_B !== op_B[win]) bad++;
            nxt();
        end
        chk("resp_hold", AMW'(bad), '0);
        req_valid = rnd_mask();
        rsp_ready = rnd_mask() | exp_hot;
        eng_done  = 1'b0;
        #1;
        chk("rsp_valid", AMW'(rsp_valid), AMW'(exp_hot));
        chk("rsp_err", AMW'(rsp_err), AMW'(exp_err));
        chk_c("rsp_C", rsp_C, exp_C);
        nxt();
        rsp_ready = '0;
        req_valid = '0;
        #1;
        chk("back_idle", AMW'({busy, rsp_valid, req_ready}), '0);
        m_ptr    = (win + 1) % NREQ;
        m_last_C = exp_C;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int bad;
        reset     = 1'b0;
        req_valid = '1;
        rsp_ready = '0;
        eng_done  = 1'b1;
        eng_C     = rnd_c();
        rand_ops();
        drive_ops();
        nxt();
        nxt();
        #1;
        chk("rst_ready", AMW'(req_ready), '0);
        chk("rst_ctrl", AMW'({busy, eng_start, rsp_err, rsp_valid}), '0);
        chk("rst_engA", eng_A, '0);
        chk("rst_engB", eng_B, '0);
        chk_c("rst_rspC", rsp_C, '0);
        reset     = 1'b1;
        req_valid = '0;
        eng_done  = 1'b0;

        // Known-answer job on requester 0, engine answers 20 cycles after start.
        rand_ops();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                op_A[0][(r*8+c)*DW +: DW] = DW'((r % 2 == 0) ? c + 1 : 8 - c);
                op_B[0][(r*8+c)*DW +: DW] = DW'(((r + c) % 2 == 0) ? 1 : 0);
            end
        run_job(4'b0001, 20, 0, 1'b0, w);
        chk("ka_owner", AMW'(w), 0);
        chk("ka_C00", AMW'(rsp_C[0*AW +: AW]), 16);
        chk("ka_C01", AMW'(rsp_C[1*AW +: AW]), 20);
        chk("ka_C10", AMW'(rsp_C[8*AW +: AW]), 20);
        chk("ka_C11", AMW'(rsp_C[9*AW +: AW]), 16);
        chk("ka_starts", AMW'(n_start), 1);

        // Round-robin order from a fresh pointer.
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            rand_ops();
            run_job(4'b1111, 3 + i, 0, 1'b0, w);
            chk($sformatf("rr_all_%0d", i), AMW'(w), AMW'(i));
        end
        rand_ops();
        run_job(4'b0101, 4, 0, 1'b0, w);
        chk("rr_0101_a", AMW'(w), 0);
        rand_ops();
        run_job(4'b0101, 4, 0, 1'b0, w);
        chk("rr_0101_b", AMW'(w), 2);

        // Backpressure, then timeout, then done colliding with the last WAIT cycle.
        rand_ops();
        run_job(rnd_mask() | 4'b0001, 7, 5, 1'b1, w);
        rand_ops();
        run_job(4'b1000, 0, 2, 1'b0, w);
        rand_ops();
        run_job(4'b0110, TIMEOUT, 1, 1'b0, w);
        rand_ops();
        run_job(4'b0010, TIMEOUT - 1, 0, 1'b0, w);

        // Reset in the middle of WAIT aborts the job; a late done is ignored.
        rand_ops();
        drive_ops();
        req_valid = 4'b0100;
        #1;
        chk("ab_grant", AMW'(req_ready), AMW'(NREQ'(1) << rr_pick(4'b0100, m_ptr)));
        nxt();
        req_valid = '0;
        m_starts++;
        nxt();
        nxt();
        nxt();
        reset = 1'b0;
        nxt();
        reset = 1'b1;
        #1;
        chk("ab_ctrl", AMW'({busy, eng_start, rsp_err, rsp_valid, req_ready}), '0);
        chk("ab_engA", eng_A, '0);
        chk("ab_engB", eng_B, '0);
        chk_c("ab_rspC", rsp_C, '0);
        m_ptr    = 0;
        m_last_C = '0;
        eng_done = 1'b1;
        eng_C    = rnd_c();
        nxt();
        eng_done = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (rsp_valid !== '0 || busy !== 1'b0 || eng_start !== 1'b0) bad++;
            nxt();
        end
        chk("ab_late_done", AMW'(bad), '0);
        rand_ops();
        run_job(4'b1001, 5, 0, 1'b0, w);
        chk("ab_ptr_cleared", AMW'(w), 0);

        // Random traffic.
        for (int i = 0; i < 30; i++) begin
            logic [NREQ-1:0] m;
            int d;
            m = rnd_mask();
            if (m == '0) m = NREQ'(1) << (i % NREQ);
            d = $urandom_range(1, 30);
            if (i == 7)  d = TIMEOUT;
            if (i == 15) d = 0;
            if (i == 21) d = 1;
            rand_ops();
            run_job(m, d, $urandom_range(0, 4), 1'($urandom), w);
        end

        chk("start_total", AMW'(n_start), AMW'(m_starts));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
